// File: rtl/uart_line_buffer.sv
// rtl/uart_line_buffer.sv - line buffer that collects received UART bytes and replays each line to the transmitter
module uart_line_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_data_avail,
  input  logic [7:0]        i_data_byte,
  input  logic              i_tx_active,
  input  logic              i_tx_done,
  output logic              o_tx_avail,
  output logic [7:0]        o_tx_byte,
  output logic              o_busy,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow
);

  typedef enum logic [2:0] {
    COLLECT,
    LOAD,
    STROBE,
    WAIT_DONE,
    SEND_LF
  } state_t;

  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]      CR   = 8'h0D;
  localparam logic [7:0]      BS   = 8'h08;
  localparam logic [7:0]      LF   = 8'h0A;

  state_t          state;
  logic [7:0]      buffer [DEPTH];
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] next_ptr;
  logic            got_cr;
  logic            lf_wait;
  logic            store;

  assign store    = (state == COLLECT) && i_data_avail && (i_data_byte != BS);
  assign next_ptr = rd_ptr + ONE;
  assign o_busy   = (state != COLLECT);
  assign o_count  = count;

  // Buffer storage is not reset; count alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (store) begin
      buffer[count[ADDR_W-1:0]] <= i_data_byte;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= COLLECT;
      count      <= '0;
      rd_ptr     <= '0;
      o_tx_avail <= 1'b0;
      o_tx_byte  <= 8'h00;
      o_overflow <= 1'b0;
      got_cr     <= 1'b0;
      lf_wait    <= 1'b0;
    end else begin
      o_tx_avail <= 1'b0;
      if (i_data_avail && (state != COLLECT)) begin
        o_overflow <= 1'b1;
      end
      case (state)
        COLLECT: begin
          if (i_data_avail) begin
            if (i_data_byte == BS) begin
              if (count != '0) begin
                count <= count - ONE;
              end
            end else begin
              count <= count + ONE;
              // A CR landing on the last free slot counts as a normal CR line.
              if ((i_data_byte == CR) || (count + ONE == FULL)) begin
                got_cr <= (i_data_byte == CR);
                state  <= LOAD;
              end
            end
          end
        end
        LOAD: begin
          rd_ptr    <= '0;
          o_tx_byte <= buffer[0];
          state     <= STROBE;
        end
        STROBE: begin
          if (!i_tx_active) begin
            o_tx_avail <= 1'b1;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (i_tx_done) begin
            rd_ptr <= next_ptr;
            if (next_ptr < count) begin
              o_tx_byte <= buffer[next_ptr[ADDR_W-1:0]];
              state     <= STROBE;
            end else if (got_cr) begin
              o_tx_byte <= LF;
              lf_wait   <= 1'b0;
              state     <= SEND_LF;
            end else begin
              count <= '0;
              state <= COLLECT;
            end
          end
        end
        SEND_LF: begin
          if (!lf_wait) begin
            if (!i_tx_active) begin
              o_tx_avail <= 1'b1;
              lf_wait    <= 1'b1;
            end
          end else if (i_tx_done) begin
            count   <= '0;
            lf_wait <= 1'b0;
            state   <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_line_buffer.sv
// tb/tb_uart_line_buffer.sv - directed bench for uart_line_buffer with a behavioural transmitter
module tb_uart_line_buffer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_byte;
  logic       avail_a, avail_b;
  logic       act_m, act_h, done_m, done_h;
  logic       tx_active, tx_done;

  logic       a_tx_avail, a_busy, a_overflow;
  logic [7:0] a_tx_byte;
  logic [6:0] a_count;
  logic       b_tx_avail, b_busy, b_overflow;
  logic [7:0] b_tx_byte;
  logic [2:0] b_count;

  int errors = 0;
  int checks = 0;

  logic       sel, tx_auto, aborted, model_busy;
  logic       m_avail;
  logic [7:0] m_byte, tx_cur;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] b;
    int         cnt;
  } vec_t;
  vec_t vecs[8];

  always #5 clock = ~clock;

  assign tx_active = act_m | act_h;
  assign tx_done   = done_m | done_h;
  assign m_avail   = sel ? b_tx_avail : a_tx_avail;
  assign m_byte    = sel ? b_tx_byte : a_tx_byte;

  uart_line_buffer dut_a (
    .clock(clock), .reset(reset), .i_data_avail(avail_a), .i_data_byte(data_byte),
    .i_tx_active(tx_active), .i_tx_done(tx_done), .o_tx_avail(a_tx_avail),
    .o_tx_byte(a_tx_byte), .o_busy(a_busy), .o_count(a_count), .o_overflow(a_overflow)
  );

  uart_line_buffer #(.DEPTH(4), .ADDR_W(2)) dut_b (
    .clock(clock), .reset(reset), .i_data_avail(avail_b), .i_data_byte(data_byte),
    .i_tx_active(tx_active), .i_tx_done(tx_done), .o_tx_avail(b_tx_avail),
    .o_tx_byte(b_tx_byte), .o_busy(b_busy), .o_count(b_count), .o_overflow(b_overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transmitter: accepts a strobe, stays active ~10 cycles, then pulses done.
  initial begin
    act_m = 1'b0;
    done_m = 1'b0;
    model_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_auto && m_avail) begin
        tx_cur = m_byte;
        tx_q.push_back(tx_cur);
        model_busy = 1'b1;
        act_m = 1'b1;
        @(negedge clock);
        check("no_back_to_back_strobe", int'(m_avail), 0);
        repeat (8) @(negedge clock);
        if (!aborted) check("tx_byte_stable", int'(m_byte), int'(tx_cur));
        done_m = 1'b1;
        act_m = 1'b0;
        @(negedge clock);
        done_m = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit to_b);
    @(negedge clock);
    data_byte = b;
    if (to_b) avail_b = 1'b1;
    else avail_a = 1'b1;
    @(negedge clock);
    avail_a = 1'b0;
    avail_b = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (((sel ? b_busy : a_busy) || model_busy) && n <= 3000) begin
      @(negedge clock);
      n++;
    end
    check(name, int'(n > 3000), 0);
  endtask

  task automatic check_seq(input string name);
    check({name, "_len"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", name, i), int'(tx_q[i]), int'(exp_q[i]));
    end
  endtask

  initial begin
    int lat, held, extra, n;
    vecs[0] = '{8'h08, 0};
    vecs[1] = '{8'h41, 1};
    vecs[2] = '{8'h42, 2};
    vecs[3] = '{8'h08, 1};
    vecs[4] = '{8'h08, 0};
    vecs[5] = '{8'h08, 0};
    vecs[6] = '{8'h78, 1};
    vecs[7] = '{8'h08, 0};

    sel = 1'b0; tx_auto = 1'b1; aborted = 1'b0;
    act_h = 1'b0; done_h = 1'b0;
    avail_a = 1'b0; avail_b = 1'b0; data_byte = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_count", int'(a_count), 0);
    check("reset_busy", int'(a_busy), 0);
    check("reset_tx_avail", int'(a_tx_avail), 0);
    check("reset_overflow", int'(a_overflow), 0);
    check("reset_tx_byte", int'(a_tx_byte), 0);
    check("reset_b_count", int'(b_count), 0);

    // Collect-only edits, including backspace at empty
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].b, 1'b0);
      check($sformatf("vec%0d_count", i), int'(a_count), vecs[i].cnt);
      check($sformatf("vec%0d_busy", i), int'(a_busy), 0);
    end
    check("vec_overflow", int'(a_overflow), 0);

    // "Hi" CR echo with latency
    tx_q.delete();
    send(8'h48, 1'b0);
    send(8'h69, 1'b0);
    send(8'h0D, 1'b0);
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (a_tx_avail && lat == 0) lat = k;
    end
    check("first_strobe_latency_ok", int'(lat >= 2 && lat <= 3), 1);
    wait_idle("hi_timeout");
    exp_q = '{8'h48, 8'h69, 8'h0D, 8'h0A};
    check_seq("hi");
    check("hi_count_after", int'(a_count), 0);

    // Backspace inside a line
    tx_q.delete();
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h08, 1'b0);
    send(8'h43, 1'b0);
    send(8'h0D, 1'b0);
    wait_idle("bs_timeout");
    exp_q = '{8'h41, 8'h43, 8'h0D, 8'h0A};
    check_seq("bs");

    // Full-buffer flush on the DEPTH=4 instance
    sel = 1'b1;
    tx_q.delete();
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    check("full_busy", int'(b_busy), 1);
    check("full_count", int'(b_count), 4);
    repeat (5) @(negedge clock);
    send(8'h05, 1'b1);
    check("full_overflow_set", int'(b_overflow), 1);
    wait_idle("full_timeout");
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_seq("full");
    check("full_count_after", int'(b_count), 0);
    check("full_overflow_sticky", int'(b_overflow), 1);
    sel = 1'b0;

    // Strobe held off while transmitter active
    tx_auto = 1'b0;
    tx_q.delete();
    @(negedge clock);
    act_h = 1'b1;
    send(8'h51, 1'b0);
    send(8'h0D, 1'b0);
    held = 0;
    repeat (6) begin
      @(negedge clock);
      if (a_tx_avail) held++;
    end
    check("avail_held_while_active", held, 0);
    check("held_busy", int'(a_busy), 1);
    act_h = 1'b0;
    @(negedge clock);
    check("strobe_after_active_falls", int'(a_tx_avail), 1);
    check("held_tx_byte", int'(a_tx_byte), 8'h51);
    @(negedge clock);
    check("held_single_pulse", int'(a_tx_avail), 0);
    act_h = 1'b1;
    repeat (3) @(negedge clock);
    done_h = 1'b1;
    act_h = 1'b0;
    @(negedge clock);
    done_h = 1'b0;
    tx_auto = 1'b1;
    wait_idle("held_timeout");
    exp_q = '{8'h0D, 8'h0A};
    check_seq("held_rest");

    // Reset in the middle of a replay
    tx_q.delete();
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    send(8'h64, 1'b0);
    send(8'h0D, 1'b0);
    n = 0;
    while (tx_q.size() < 2 && n <= 500) begin
      @(negedge clock);
      n++;
    end
    check("abort_wait_timeout", int'(n > 500), 0);
    aborted = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_tx_avail", int'(a_tx_avail), 0);
    check("abort_busy", int'(a_busy), 0);
    check("abort_count", int'(a_count), 0);
    check("abort_overflow", int'(a_overflow), 0);
    extra = 0;
    repeat (20) begin
      @(negedge clock);
      if (a_tx_avail) extra++;
    end
    check("abort_no_more_strobes", extra, 0);
    aborted = 1'b0;
    wait_idle("abort_idle_timeout");
    tx_q.delete();
    send(8'h5A, 1'b0);
    send(8'h0D, 1'b0);
    wait_idle("z_timeout");
    exp_q = '{8'h5A, 8'h0D, 8'h0A};
    check_seq("z");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
